seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_scan_if.sv | 24 ++
 rtl/seg7_scan.sv | 129 ++++++++++++
 tb/tb_seg7_scan.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// rtl/seg7_scan_if.sv - display control and drive signals for the multiplexed seven-segment scanner
interface seg7_scan_if #(
  parameter int DIGITS = 4
);
  logic                  enable;
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic                  blank_lz;
  logic [6:0]            seg;
  logic                  dp_n;
  logic [DIGITS-1:0]     an_n;
  logic                  frame_start;

  modport master (
    output enable, load, value, dp_in, blank_lz,
    input  seg, dp_n, an_n, frame_start
  );

  modport slave (
    input  enable, load, value, dp_in, blank_lz,
    output seg, dp_n, an_n, frame_start
  );
endinterface

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - multiplexed hex seven-segment scanner with double-buffered data, guard blanking and leading-zero suppression
module seg7_scan #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 2
) (
  input logic          clk,
  input logic          reset,
  seg7_scan_if.slave   bus
);
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNTW = $clog2(REFRESH_DIV);
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(DIGITS - 1);
  localparam logic [CNTW-1:0] LAST_CNT  = CNTW'(REFRESH_DIV - 1);
  localparam logic [CNTW-1:0] GUARD_CNT = CNTW'(GUARD);

  logic [CNTW-1:0]          cnt_q, cnt_d;
  logic [IDXW-1:0]          idx_q, idx_d;
  logic [DIGITS-1:0][3:0]   act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [DIGITS-1:0]        act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                     pend_flag_q, pend_flag_d;
  logic [6:0]               seg_q, seg_d;
  logic                     dp_n_q, dp_n_d;
  logic [DIGITS-1:0]        an_n_q, an_n_d;
  logic                     fs_q, fs_d;
  logic                     slot_end, frame_end, all_zero;
  logic [DIGITS-1:0]        lz_blank;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h01;  4'h1: glyph = 7'h4F;  4'h2: glyph = 7'h12;  4'h3: glyph = 7'h06;
      4'h4: glyph = 7'h4C;  4'h5: glyph = 7'h24;  4'h6: glyph = 7'h20;  4'h7: glyph = 7'h0F;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h04;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h60;
      4'hC: glyph = 7'h31;  4'hD: glyph = 7'h42;  4'hE: glyph = 7'h30;  default: glyph = 7'h38;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      act_val_q   <= '0;
      act_dp_q    <= '0;
      pend_val_q  <= '0;
      pend_dp_q   <= '0;
      pend_flag_q <= 1'b0;
      seg_q       <= 7'h7F;
      dp_n_q      <= 1'b1;
      an_n_q      <= '1;
      fs_q        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      act_val_q   <= act_val_d;
      act_dp_q    <= act_dp_d;
      pend_val_q  <= pend_val_d;
      pend_dp_q   <= pend_dp_d;
      pend_flag_q <= pend_flag_d;
      seg_q       <= seg_d;
      dp_n_q      <= dp_n_d;
      an_n_q      <= an_n_d;
      fs_q        <= fs_d;
    end
  end

  // Scan position plus double buffer; active data only changes as idx wraps to 0.
  always_comb begin
    slot_end    = bus.enable && (cnt_q == LAST_CNT);
    frame_end   = slot_end && (idx_q == LAST_IDX);
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    act_val_d   = act_val_q;
    act_dp_d    = act_dp_q;
    pend_val_d  = pend_val_q;
    pend_dp_d   = pend_dp_q;
    pend_flag_d = pend_flag_q;
    if (bus.enable) begin
      if (slot_end) begin
        cnt_d = '0;
        idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (frame_end) begin
      if (bus.load) begin
        act_val_d  = bus.value;
        act_dp_d   = bus.dp_in;
        pend_val_d = bus.value;
        pend_dp_d  = bus.dp_in;
      end else if (pend_flag_q) begin
        act_val_d  = pend_val_q;
        act_dp_d   = pend_dp_q;
      end
      pend_flag_d = 1'b0;
    end else if (bus.load) begin
      pend_val_d  = bus.value;
      pend_dp_d   = bus.dp_in;
      pend_flag_d = 1'b1;
    end
  end

  // A digit is a leading zero when it and every more significant digit are zero.
  always_comb begin
    all_zero = 1'b1;
    lz_blank = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero && (act_val_q[i] == 4'h0);
      if (i > 0) lz_blank[i] = all_zero;
    end
  end

  always_comb begin
    seg_d  = 7'h7F;
    dp_n_d = 1'b1;
    an_n_d = '1;
    fs_d   = bus.enable && (cnt_q == '0) && (idx_q == '0);
    if (bus.enable && !(bus.blank_lz && lz_blank[idx_q])) begin
      seg_d  = glyph(act_val_q[idx_q]);
      dp_n_d = ~act_dp_q[idx_q];
      if (cnt_q >= GUARD_CNT) an_n_d = ~(DIGITS'(1) << idx_q);
    end
  end

  assign bus.seg         = seg_q;
  assign bus.dp_n        = dp_n_q;
  assign bus.an_n        = an_n_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - self-checking bench for seg7_scan against a frame-position reference model
module tb_seg7_scan;
  localparam int DIGITS = 4;
  localparam int RD     = 8;
  localparam int GUARD  = 2;
  localparam int FRAME  = DIGITS * RD;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seg7_scan_if #(.DIGITS(DIGITS)) bus();

  seg7_scan #(.DIGITS(DIGITS), .REFRESH_DIV(RD), .GUARD(GUARD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [6:0] glyph_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                 7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  int errors = 0;
  int checks = 0;

  // Model: m_t counts enabled cycles since reset; frame position is m_t mod FRAME.
  int          m_t;
  logic [15:0] m_show, m_pend;
  logic [3:0]  m_sdp, m_pdp;
  bit          m_pf;
  int          last_pos;
  bit          blz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit en, input bit ld, input logic [15:0] v, input logic [3:0] dp, input bit rst);
    logic [6:0] e_seg;
    logic       e_dp, e_fs;
    logic [3:0] e_an, nib;
    int pos, d, c;
    reset = rst; bus.enable = en; bus.load = ld; bus.value = v; bus.dp_in = dp; bus.blank_lz = blz;
    pos = m_t % FRAME; d = pos / RD; c = pos % RD;
    e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_fs = 1'b0;
    if (!rst && en) begin
      e_fs = (pos == 0);
      nib  = 4'((m_show >> (4 * d)) & 16'hF);
      if (!(blz && d > 0 && (m_show >> (4 * d)) == 16'h0)) begin
        e_seg = glyph_tab[nib];
        e_dp  = ~m_sdp[d];
        if (c >= GUARD) e_an = ~(4'b0001 << d);
      end
    end
    last_pos = (!rst && en) ? pos : -1;
    if (rst) begin
      m_t = 0; m_show = '0; m_pend = '0; m_sdp = '0; m_pdp = '0; m_pf = 1'b0;
    end else begin
      if (en && pos == FRAME - 1) begin
        if (ld) begin
          m_show = v; m_sdp = dp; m_pend = v; m_pdp = dp;
        end else if (m_pf) begin
          m_show = m_pend; m_sdp = m_pdp;
        end
        m_pf = 1'b0;
      end else if (ld) begin
        m_pend = v; m_pdp = dp; m_pf = 1'b1;
      end
      if (en) m_t++;
    end
    @(posedge clk); #1;
    check("seg", 32'(bus.seg), 32'(e_seg));
    check("dp_n", 32'(bus.dp_n), 32'(e_dp));
    check("an_n", 32'(bus.an_n), 32'(e_an));
    check("frame_start", 32'(bus.frame_start), 32'(e_fs));
  endtask

  task automatic run_until_shown(input int p);
    for (int k = 0; k < 4 * FRAME; k++) begin
      step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
      if (last_pos == p) return;
    end
    checks++;
    errors++;
    $error("FAIL run_until_shown: position %0d not reached", p);
  endtask

  initial begin
    blz = 1'b0;
    m_t = 0; m_show = '0; m_pend = '0; m_sdp = '0; m_pdp = '0; m_pf = 1'b0;
    repeat (3) step(1'b1, 1'b1, 16'hFFFF, 4'hF, 1'b1);
    check("reset_an", 32'(bus.an_n), 32'hF);
    check("reset_seg", 32'(bus.seg), 32'h7F);

    // 1234 appears after the first frame boundary
    step(1'b1, 1'b1, 16'h1234, 4'h0, 1'b0);
    run_until_shown(FRAME - 1);
    run_until_shown(2);
    check("d0_seg_1234", 32'(bus.seg), 32'h4C);
    check("d0_an", 32'(bus.an_n), 32'hE);
    run_until_shown(10);
    check("d1_seg_1234", 32'(bus.seg), 32'h06);
    check("d1_an", 32'(bus.an_n), 32'hD);
    run_until_shown(24);
    check("d3_guard_an", 32'(bus.an_n), 32'hF);
    check("d3_guard_seg", 32'(bus.seg), 32'h4F);
    run_until_shown(26);
    check("d3_an", 32'(bus.an_n), 32'h7);

    // mid-frame load waits for the next frame
    run_until_shown(FRAME - 1);
    run_until_shown(10);
    step(1'b1, 1'b1, 16'hABCD, 4'b0101, 1'b0);
    run_until_shown(18);
    check("midframe_hold", 32'(bus.seg), 32'h12);
    run_until_shown(FRAME - 1);
    run_until_shown(2);
    check("abcd_d0", 32'(bus.seg), 32'h42);
    check("abcd_dp0", 32'(bus.dp_n), 32'h0);

    // leading-zero blanking
    blz = 1'b1;
    step(1'b1, 1'b1, 16'h0007, 4'b1000, 1'b0);
    run_until_shown(FRAME - 1);
    run_until_shown(2);
    check("lz_d0", 32'(bus.seg), 32'h0F);
    run_until_shown(26);
    check("lz_d3_an", 32'(bus.an_n), 32'hF);
    check("lz_d3_seg", 32'(bus.seg), 32'h7F);
    check("lz_d3_dp", 32'(bus.dp_n), 32'h1);
    step(1'b1, 1'b1, 16'h0000, 4'h0, 1'b0);
    run_until_shown(FRAME - 1);
    run_until_shown(2);
    check("lz_zero_d0", 32'(bus.seg), 32'h01);
    run_until_shown(10);
    check("lz_zero_d1", 32'(bus.an_n), 32'hF);
    blz = 1'b0;

    // last load before the boundary wins; boundary-cycle load is immediate
    step(1'b1, 1'b1, 16'h1111, 4'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    step(1'b1, 1'b1, 16'h2222, 4'h0, 1'b0);
    run_until_shown(FRAME - 1);
    run_until_shown(18);
    check("two_loads", 32'(bus.seg), 32'h12);
    run_until_shown(FRAME - 2);
    step(1'b1, 1'b1, 16'h5555, 4'h0, 1'b0);
    run_until_shown(2);
    check("boundary_load", 32'(bus.seg), 32'h24);

    // freeze and resume in the middle of a slot
    run_until_shown(12);
    repeat (20) step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    check("frozen_an", 32'(bus.an_n), 32'hF);
    step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    check("resume_an", 32'(bus.an_n), 32'hD);
    check("resume_seg", 32'(bus.seg), 32'h24);

    // reset with data pending
    step(1'b1, 1'b1, 16'h9999, 4'hF, 1'b0);
    step(1'b1, 1'b1, 16'h8888, 4'hF, 1'b1);
    check("rst_dark", 32'(bus.an_n), 32'hF);
    run_until_shown(2);
    check("rst_d0_seg", 32'(bus.seg), 32'h01);
    check("rst_d0_an", 32'(bus.an_n), 32'hE);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (i % 64 == 0) blz = 1'($urandom);
      step($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0,
           16'($urandom), 4'($urandom), $urandom_range(0, 149) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
